tree_router_node_sync: RTL and testbench

//  Synchronous, parametrised NoC tree router node: one parent port plus 2**CHILD_BITS child ports.

---
 rtl/tree_router_node_sync_if.sv | 12 +
 rtl/tree_router_node_sync.sv | 197 +++++++++++++++++++
 tb/tb_tree_router_node_sync.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tree_router_node_sync_if.sv
// Valid/ready flit bundle covering every port of a router node; slice p of data belongs to port p.
interface tree_router_node_sync_if #(
    parameter int NP = 3,
    parameter int W  = 14
);
    logic [NP-1:0]   valid;
    logic [NP*W-1:0] data;
    logic [NP-1:0]   ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/tree_router_node_sync.sv
// K-ary tree router node: per-input FIFO, per-output round-robin arbiter feeding a one-entry
// output register. Port 0 faces the parent, port 1+c faces child c.

module tree_router_node_sync_fifo #(
    parameter int W     = 14,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         head_vld,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // No fall-through: a push into an empty FIFO shows at the head one cycle later.
    assign head     = mem[rd_ptr];
    assign head_vld = (cnt != '0);
    assign full     = cnt[AW];
endmodule

module tree_router_node_sync_outp #(
    parameter int W  = 14,
    parameter int NP = 3,
    parameter int PW = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NP-1:0]         req,
    input  logic [NP-1:0][W-1:0]  heads,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [W-1:0]          out_data,
    output logic [NP-1:0]         gnt
);
    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;
    logic          load_ok;

    // Round-robin: first requester at or above ptr, else first requester below it.
    always_comb begin
        gnt     = '0;
        gidx    = ptr;
        found   = 1'b0;
        load_ok = !out_valid || out_ready;
        for (int i = 0; i < NP; i++) begin
            if (!found && req[i] && (PW'(i) >= ptr)) begin
                found = 1'b1;
                gidx  = PW'(i);
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                gidx  = PW'(i);
            end
        end
        if (found && load_ok) gnt[gidx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (|gnt) begin
            out_valid <= 1'b1;
            out_data  <= heads[gidx];
            ptr       <= (gidx == PW'(NP-1)) ? '0 : gidx + PW'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

module tree_router_node_sync #(
    parameter int WIDTH_PACKET = 14,
    parameter int CHILD_BITS   = 1,
    parameter int LEVELS       = 3,
    parameter int LEVEL        = 2,
    parameter logic [CHILD_BITS*LEVELS-1:0] NODE_ADDR = '0,
    parameter int DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    tree_router_node_sync_if.slave   in_if,
    tree_router_node_sync_if.master  out_if,
    output logic                     err_misroute
);
    localparam int K      = 2**CHILD_BITS;
    localparam int NP     = K + 1;
    localparam int W      = WIDTH_PACKET;
    localparam int ADDR_W = CHILD_BITS * LEVELS;
    localparam int PW     = $clog2(NP);
    localparam int PFX_W  = LEVEL * CHILD_BITS;
    localparam int SH     = ADDR_W - PFX_W - CHILD_BITS;
    // Mask over the address bits this node's ancestors already resolved; zero at the root.
    localparam logic [ADDR_W-1:0] PFX_MASK = ~({ADDR_W{1'b1}} >> PFX_W);

    logic [NP-1:0][W-1:0]  heads;
    logic [NP-1:0]         head_vld;
    logic [NP-1:0]         full;
    logic [NP-1:0]         push;
    logic [NP-1:0]         pop;
    logic [NP-1:0]         drop;
    logic [NP-1:0][PW-1:0] tgt;
    logic [NP-1:0][NP-1:0] req;
    logic [NP-1:0][NP-1:0] gnt;
    logic [NP-1:0]         ov;
    logic [NP-1:0][W-1:0]  od;

    assign in_if.ready  = ~full & {NP{~reset}};
    assign push         = in_if.valid & in_if.ready;
    assign out_if.valid = ov;
    assign out_if.data  = od;

    for (genvar p = 0; p < NP; p++) begin : g_in
        logic [ADDR_W-1:0] dest;

        tree_router_node_sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push[p]),
            .din      (in_if.data[p*W +: W]),
            .pop      (pop[p]),
            .head     (heads[p]),
            .head_vld (head_vld[p]),
            .full     (full[p])
        );

        assign dest   = heads[p][W-1 -: ADDR_W];
        assign tgt[p] = (((dest ^ NODE_ADDR) & PFX_MASK) == '0)
                      ? PW'(dest[SH +: CHILD_BITS]) + PW'(1) : '0;
        // Parent traffic bound back upward has nowhere to go: discard it.
        assign drop[p] = (p == 0) && head_vld[p] && (tgt[p] == '0);
    end

    for (genvar o = 0; o < NP; o++) begin : g_out
        for (genvar i = 0; i < NP; i++) begin : g_req
            assign req[o][i] = head_vld[i] && (tgt[i] == PW'(o)) && !drop[i];
        end

        tree_router_node_sync_outp #(.W(W), .NP(NP), .PW(PW)) u_outp (
            .clk       (clk),
            .reset     (reset),
            .req       (req[o]),
            .heads     (heads),
            .out_ready (out_if.ready[o]),
            .out_valid (ov[o]),
            .out_data  (od[o]),
            .gnt       (gnt[o])
        );
    end

    always_comb begin
        pop = drop;
        for (int o = 0; o < NP; o++) begin
            for (int i = 0; i < NP; i++) begin
                pop[i] = pop[i] | gnt[o][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)        err_misroute <= 1'b0;
        else if (drop[0]) err_misroute <= 1'b1;
    end
endmodule

// File: tb/tb_tree_router_node_sync.sv
// Bench for a binary leaf-level router node (node 3'b010): directed routing/latency,
// fairness, backpressure, misroute and reset, plus a random run against a flit scoreboard.
module tb_tree_router_node_sync;
    localparam int W      = 14;
    localparam int CB     = 1;
    localparam int LEVELS = 3;
    localparam int LEVEL  = 2;
    localparam int DEPTH  = 4;
    localparam int K      = 2;
    localparam int NP     = 3;
    localparam int ADDR_W = 3;
    localparam logic [2:0] NODE = 3'b010;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic err_misroute;

    tree_router_node_sync_if #(.NP(NP), .W(W)) in_if ();
    tree_router_node_sync_if #(.NP(NP), .W(W)) out_if ();

    tree_router_node_sync #(
        .WIDTH_PACKET (W),
        .CHILD_BITS   (CB),
        .LEVELS       (LEVELS),
        .LEVEL        (LEVEL),
        .NODE_ADDR    (NODE),
        .DEPTH        (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_if        (in_if),
        .out_if       (out_if),
        .err_misroute (err_misroute)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct { int src; int dst; logic [W-1:0] flit; } exp_t;
    typedef struct { int o; int cyc; logic [W-1:0] flit; } got_t;
    exp_t exp_q[$];
    got_t got_log[$];
    logic [W-1:0] snd_buf [NP][512];
    int snd_rd [NP];
    int snd_wr [NP];
    bit exp_err;
    bit hold_pend [NP];
    logic [W-1:0] hold_dat [NP];

    // Reference routing: local subtree -> child selected by the next address digit, else up.
    function automatic int route(int src, logic [W-1:0] f);
        int dest = int'(f[W-1 -: ADDR_W]);
        int sh = ADDR_W - LEVEL * CB;
        if ((dest >> sh) == (int'(NODE) >> sh)) return 1 + ((dest >> (sh - CB)) % K);
        return (src == 0) ? -1 : 0;
    endfunction

    function automatic bit pending();
        bit r = 0;
        for (int p = 0; p < NP; p++) if (snd_rd[p] < snd_wr[p]) r = 1;
        return r;
    endfunction

    task automatic snd_push(int p, logic [W-1:0] f);
        snd_buf[p][snd_wr[p]] = f;
        snd_wr[p]++;
    endtask

    task automatic present();
        for (int p = 0; p < NP; p++) begin
            in_if.valid[p] = (snd_rd[p] < snd_wr[p]);
            in_if.data[p*W +: W] = (snd_rd[p] < snd_wr[p]) ? snd_buf[p][snd_rd[p]] : '0;
        end
    endtask

    task automatic model_accept(int p, logic [W-1:0] f);
        int d = route(p, f);
        if (d < 0) exp_err = 1;
        else exp_q.push_back('{p, d, f});
    endtask

    // An output flit must be the oldest outstanding flit of some source bound for that output.
    task automatic sb_out(int o, logic [W-1:0] f);
        int hit = -1;
        for (int j = 0; j < exp_q.size() && hit < 0; j++) begin
            if (exp_q[j].dst == o && exp_q[j].flit == f) begin
                bit older = 0;
                for (int k = 0; k < j; k++)
                    if (exp_q[k].dst == o && exp_q[k].src == exp_q[j].src) older = 1;
                if (!older) hit = j;
            end
        end
        checks++;
        if (hit < 0) begin
            errors++;
            $display("FAIL scoreboard out%0d: got %h, no outstanding flit matches", o, f);
        end else begin
            exp_q.delete(hit);
        end
        got_log.push_back('{o, cyc, f});
    endtask

    task automatic tick();
        bit acc [NP];
        @(negedge clk);
        for (int p = 0; p < NP; p++) acc[p] = in_if.valid[p] && in_if.ready[p];
        for (int o = 0; o < NP; o++) begin
            if (hold_pend[o]) begin
                checks++;
                if (out_if.valid[o] !== 1'b1 || out_if.data[o*W +: W] !== hold_dat[o]) begin
                    errors++;
                    $display("FAIL hold out%0d: got v=%b d=%h, want v=1 d=%h", o,
                             out_if.valid[o], out_if.data[o*W +: W], hold_dat[o]);
                end
            end
            hold_pend[o] = out_if.valid[o] && !out_if.ready[o];
            hold_dat[o]  = out_if.data[o*W +: W];
            if (!reset && out_if.valid[o] && out_if.ready[o]) sb_out(o, out_if.data[o*W +: W]);
        end
        for (int p = 0; p < NP; p++) if (acc[p]) model_accept(p, snd_buf[p][snd_rd[p]]);
        cyc++;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) if (acc[p]) snd_rd[p]++;
        present();
    endtask

    task automatic clear_model();
        for (int p = 0; p < NP; p++) begin
            snd_rd[p] = 0;
            snd_wr[p] = 0;
            hold_pend[p] = 0;
        end
        exp_q.delete();
        got_log.delete();
        exp_err = 0;
        present();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        out_if.ready = '1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(int budget);
        int n = 0;
        out_if.ready = '1;
        while ((exp_q.size() != 0 || pending()) && n < budget) begin
            tick();
            n++;
        end
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0 || pending()) begin
            errors++;
            $display("FAIL drain: %0d flits still outstanding after %0d cycles, want 0",
                     exp_q.size(), budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_if.ready = '1;
        in_if.valid = '1;
        in_if.data = {3{14'h0ab5}};
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (in_if.ready !== 3'b000) begin
                errors++;
                $display("FAIL reset_in_ready: got %b, want 000", in_if.ready);
            end
            checks++;
            if (out_if.valid !== 3'b000 || out_if.data !== '0) begin
                errors++;
                $display("FAIL reset_out: got v=%b d=%h, want 0/0", out_if.valid, out_if.data);
            end
        end
        checks++;
        if (err_misroute !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b, want 0", err_misroute);
        end
        in_if.valid = '0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_if.ready !== 3'b111) begin
            errors++;
            $display("FAIL release_in_ready: got %b, want 111", in_if.ready);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_if.valid !== 3'b000) begin
                errors++;
                $display("FAIL reset_enqueued: got out_valid %b, want 000", out_if.valid);
            end
        end
    endtask

    // Single flits on an idle node: check route and the two-edge latency.
    task automatic test_directed_routes();
        int src [4];
        int ou [4];
        logic [W-1:0] fl [4];
        logic [NP-1:0] ev;
        src[0] = 0; fl[0] = {3'b011, 11'h155}; ou[0] = 2;
        src[1] = 0; fl[1] = {3'b010, 11'h2aa}; ou[1] = 1;
        src[2] = 1; fl[2] = {3'b110, 11'h0f3}; ou[2] = 0;
        src[3] = 1; fl[3] = {3'b010, 11'h70c}; ou[3] = 1;
        for (int k = 0; k < 4; k++) begin
            ev = NP'(1 << ou[k]);
            in_if.valid[src[k]] = 1'b1;
            in_if.data[src[k]*W +: W] = fl[k];
            checks++;
            if (in_if.ready[src[k]] !== 1'b1) begin
                errors++;
                $display("FAIL route%0d_ready: got %b, want 1", k, in_if.ready[src[k]]);
            end
            @(posedge clk);
            #1;
            in_if.valid[src[k]] = 1'b0;
            checks++;
            if (out_if.valid !== 3'b000) begin
                errors++;
                $display("FAIL route%0d_early: got out_valid %b one edge after accept, want 000",
                         k, out_if.valid);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_if.valid !== ev || out_if.data[ou[k]*W +: W] !== fl[k]) begin
                errors++;
                $display("FAIL route%0d: got v=%b d=%h, want v=%b d=%h", k, out_if.valid,
                         out_if.data[ou[k]*W +: W], ev, fl[k]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_if.valid !== 3'b000) begin
                errors++;
                $display("FAIL route%0d_drain: got out_valid %b, want 000", k, out_if.valid);
            end
        end
    endtask

    task automatic test_fairness();
        int n = 0;
        int c0 = 0;
        do_reset();
        for (int s = 0; s < 12; s++)
            for (int p = 0; p < NP; p++) snd_push(p, {3'b010, 2'(p), 9'(s)});
        present();
        drain(80);
        foreach (got_log[j]) begin
            if (got_log[j].o == 1) begin
                if (n == 0) c0 = got_log[j].cyc;
                checks++;
                if (int'(got_log[j].flit[10:9]) != n % 3 || got_log[j].cyc != c0 + n) begin
                    errors++;
                    $display("FAIL fairness grant %0d: got src %0d at cycle %0d, want src %0d at %0d",
                             n, got_log[j].flit[10:9], got_log[j].cyc, n % 3, c0 + n);
                end
                n++;
            end
        end
        checks++;
        if (n != 36) begin
            errors++;
            $display("FAIL fairness_count: got %0d flits on out1, want 36", n);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        out_if.ready = 3'b101;
        for (int i = 0; i < 6; i++) snd_push(2, {3'b010, 2'd2, 9'(i + 16)});
        present();
        repeat (10) tick();
        checks++;
        if (snd_rd[2] != 5 || in_if.ready[2] !== 1'b0) begin
            errors++;
            $display("FAIL bp_fill: got accepted=%0d in_ready=%b, want 5/0", snd_rd[2], in_if.ready[2]);
        end
        checks++;
        if (out_if.valid[1] !== 1'b1 || out_if.data[W +: W] !== snd_buf[2][0]) begin
            errors++;
            $display("FAIL bp_outreg: got v=%b d=%h, want v=1 d=%h", out_if.valid[1],
                     out_if.data[W +: W], snd_buf[2][0]);
        end
        drain(40);
        foreach (got_log[j]) begin
            if (got_log[j].o == 1) begin
                checks++;
                if (n >= 6 || got_log[j].flit !== snd_buf[2][n]) begin
                    errors++;
                    $display("FAIL bp_order %0d: got %h, want %h", n, got_log[j].flit, snd_buf[2][n % 6]);
                end
                n++;
            end
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d delivered, want 6", n);
        end
    endtask

    task automatic test_misroute_reset();
        do_reset();
        snd_push(0, {3'b100, 11'h123});
        present();
        repeat (6) tick();
        checks++;
        if (got_log.size() != 0 || err_misroute !== 1'b1) begin
            errors++;
            $display("FAIL misroute: got outputs=%0d err=%b, want 0/1", got_log.size(), err_misroute);
        end
        out_if.ready = '0;
        for (int i = 0; i < 6; i++) begin
            snd_push(0, {3'b010, 11'(i)});
            snd_push(1, {3'b011, 11'(i + 8)});
            snd_push(2, {3'b110, 11'(i + 16)});
        end
        present();
        repeat (4) tick();
        checks++;
        if (out_if.valid !== 3'b111 || err_misroute !== 1'b1) begin
            errors++;
            $display("FAIL midstream: got v=%b err=%b, want 111/1", out_if.valid, err_misroute);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_if.valid !== 3'b000 || in_if.ready !== 3'b000) begin
            errors++;
            $display("FAIL midreset: got v=%b rdy=%b, want 000/000", out_if.valid, in_if.ready);
        end
        clear_model();
        out_if.ready = '1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_if.ready !== 3'b111 || err_misroute !== 1'b0 || out_if.valid !== 3'b000) begin
            errors++;
            $display("FAIL post_reset: got rdy=%b err=%b v=%b, want 111/0/000",
                     in_if.ready, err_misroute, out_if.valid);
        end
        repeat (5) tick();
        checks++;
        if (got_log.size() != 0) begin
            errors++;
            $display("FAIL post_reset_flits: got %0d stale flits, want 0", got_log.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (300) begin
            for (int o = 0; o < NP; o++) out_if.ready[o] = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 1) == 1 && snd_wr[p] < 500) snd_push(p, W'($urandom));
            present();
            tick();
        end
        drain(2000);
        checks++;
        if (err_misroute !== exp_err) begin
            errors++;
            $display("FAIL random_err: got %b, want %b", err_misroute, exp_err);
        end
    endtask

    initial begin
        in_if.valid = '0;
        in_if.data = '0;
        out_if.ready = '1;
        clear_model();
        test_reset();
        test_directed_routes();
        test_fairness();
        test_backpressure();
        test_misroute_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
